// File: rtl/alu_rs_pkg.sv
// ---------------------------------------------------------------------------
// alu_rs_pkg
// Shared widths, opcode encodings and entry types for the integer ALU
// reservation station. Also provides the CDB snoop helper used both at
// dispatch (bypass) and in every entry (wakeup), so the two paths can never
// disagree on bus priority.
// ---------------------------------------------------------------------------
package alu_rs_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int OP_WIDTH     = 6;
  localparam int ROB_WIDTH    = 4;

  localparam int RS_SIZE_DEF  = 16;
  localparam int RS_WIDTH_DEF = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [OP_WIDTH-1:0]   op_t;
  typedef logic [ROB_WIDTH-1:0]  rob_t;

  // Decoded opcodes handled by the ALU path (ALU ops, branches, jumps).
  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_SLL   = 6'd6,
    OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,
    OP_SLT   = 6'd9,
    OP_SLTU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_ANDI  = 6'd12,
    OP_ORI   = 6'd13,
    OP_XORI  = 6'd14,
    OP_SLLI  = 6'd15,
    OP_SRLI  = 6'd16,
    OP_SRAI  = 6'd17,
    OP_SLTI  = 6'd18,
    OP_SLTIU = 6'd19,
    OP_BEQ   = 6'd20,
    OP_BNE   = 6'd21,
    OP_BLT   = 6'd22,
    OP_BGE   = 6'd23,
    OP_BLTU  = 6'd24,
    OP_BGEU  = 6'd25,
    OP_JAL   = 6'd26,
    OP_JALR  = 6'd27,
    OP_LUI   = 6'd28,
    OP_AUIPC = 6'd29
  } alu_op_e;

  // One reservation-station slot.
  typedef struct packed {
    logic  busy;
    op_t   opcode;
    addr_t pc;
    data_t vj;
    data_t vk;
    rob_t  qj;
    rob_t  qk;
    logic  qj_busy;
    logic  qk_busy;
    data_t imm;
    rob_t  rob_id;
  } rs_entry_t;

  // Operand state after looking at the CDBs.
  typedef struct packed {
    logic  pend;
    data_t val;
  } opnd_t;

  // Resolve one pending operand against both CDBs. The A bus wins if both
  // match; that case cannot legally happen but must be deterministic.
  function automatic opnd_t snoop(
    input logic  pend,
    input rob_t  tag,
    input data_t val,
    input logic  a_rdy,
    input rob_t  a_tag,
    input data_t a_val,
    input logic  l_rdy,
    input rob_t  l_tag,
    input data_t l_val
  );
    opnd_t r;
    r.pend = pend;
    r.val  = val;
    if (pend) begin
      if (a_rdy && (a_tag == tag)) begin
        r.pend = FALSE;
        r.val  = a_val;
      end else if (l_rdy && (l_tag == tag)) begin
        r.pend = FALSE;
        r.val  = l_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// ---------------------------------------------------------------------------
// alu_rs_pick
// Lowest-index priority encoder over an N-bit request vector.
//   req   : request bits, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   found : at least one request bit is set
// ---------------------------------------------------------------------------
module alu_rs_pick
  import alu_rs_pkg::*;
#(
  parameter int N = RS_SIZE_DEF,
  parameter int W = RS_WIDTH_DEF
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    found = FALSE;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = TRUE;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs
// Reservation station for the integer ALU. Buffers dispatched ALU/branch/jump
// micro-ops until both operands are available, snoops the ALU and LSB CDBs
// for wakeup, and issues at most one ready micro-op per cycle.
//
// Ports
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global enable (low freezes all state)
//   clear_in                  mispredict flush (synchronous)
//   *_disp_in / full_disp_out dispatcher interface
//   *_a_cdb_in                ALU result broadcast
//   *_l_cdb_in                LSB result broadcast
//   idle_alu_in               ALU can accept a micro-op
//   *_alu_out                 registered issue payload to the ALU
// ---------------------------------------------------------------------------
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_WIDTH = RS_WIDTH_DEF
) (
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  rdy_in,
  input  logic  clear_in,
  // dispatch
  input  logic  valid_disp_in,
  input  op_t   opcode_disp_in,
  input  addr_t pc_disp_in,
  input  data_t vj_disp_in,
  input  data_t vk_disp_in,
  input  rob_t  qj_disp_in,
  input  rob_t  qk_disp_in,
  input  logic  qj_busy_disp_in,
  input  logic  qk_busy_disp_in,
  input  data_t imm_disp_in,
  input  rob_t  rob_id_disp_in,
  output logic  full_disp_out,
  // CDBs
  input  logic  rdy_a_cdb_in,
  input  data_t result_a_cdb_in,
  input  rob_t  rob_id_a_cdb_in,
  input  logic  rdy_l_cdb_in,
  input  data_t result_l_cdb_in,
  input  rob_t  rob_id_l_cdb_in,
  // ALU
  input  logic  idle_alu_in,
  output logic  rdy_alu_out,
  output addr_t pc_alu_out,
  output op_t   opcode_alu_out,
  output data_t vj_alu_out,
  output data_t vk_alu_out,
  output data_t imm_alu_out,
  output rob_t  rob_id_alu_out
);

  localparam logic [RS_WIDTH:0] CNT_ONE  = (RS_WIDTH + 1)'(1);
  localparam logic [RS_WIDTH:0] CNT_FULL = (RS_WIDTH + 1)'(RS_SIZE);

  logic [RS_SIZE-1:0]  busy_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  rs_entry_t           ent_arr [RS_SIZE];

  logic [RS_WIDTH-1:0] free_idx;
  logic [RS_WIDTH-1:0] ready_idx;
  logic                free_found;
  logic                ready_found;

  logic                disp_accept;
  logic                issue_fire;
  rs_entry_t           disp_entry;
  opnd_t               disp_j;
  opnd_t               disp_k;

  logic [RS_WIDTH:0]   count_reg;
  logic [RS_WIDTH:0]   count_next;
  logic                full_reg;

  logic                rdy_alu_reg;
  addr_t               pc_alu_reg;
  op_t                 opcode_alu_reg;
  data_t               vj_alu_reg;
  data_t               vk_alu_reg;
  data_t               imm_alu_reg;
  rob_t                rob_id_alu_reg;

  // -------------------------------------------------------------------------
  // Slot selection. Both pickers look at registered busy state, so a slot
  // freed by issue only becomes visible as free on the following cycle.
  // -------------------------------------------------------------------------
  alu_rs_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_pick (
    .req   (~busy_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  alu_rs_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_ready_pick (
    .req   (ready_vec),
    .idx   (ready_idx),
    .found (ready_found)
  );

  // clear_in and a low rdy_in both suppress dispatch and issue.
  assign disp_accept = rdy_in && !clear_in && valid_disp_in && !full_reg && free_found;
  assign issue_fire  = rdy_in && !clear_in && idle_alu_in && ready_found;

  // -------------------------------------------------------------------------
  // Incoming entry, with same-cycle CDB bypass on pending operands.
  // -------------------------------------------------------------------------
  always_comb begin
    disp_j = snoop(qj_busy_disp_in, qj_disp_in, vj_disp_in,
                   rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
                   rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);
    disp_k = snoop(qk_busy_disp_in, qk_disp_in, vk_disp_in,
                   rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
                   rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);

    disp_entry         = '0;
    disp_entry.busy    = TRUE;
    disp_entry.opcode  = opcode_disp_in;
    disp_entry.pc      = pc_disp_in;
    disp_entry.vj      = disp_j.val;
    disp_entry.vk      = disp_k.val;
    disp_entry.qj      = qj_disp_in;
    disp_entry.qk      = qk_disp_in;
    disp_entry.qj_busy = disp_j.pend;
    disp_entry.qk_busy = disp_k.pend;
    disp_entry.imm     = imm_disp_in;
    disp_entry.rob_id  = rob_id_disp_in;
  end

  // -------------------------------------------------------------------------
  // Entry storage: one register slot per generate iteration.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
    rs_entry_t ent_reg;
    rs_entry_t ent_next;
    opnd_t     j_snoop;
    opnd_t     k_snoop;

    always_comb begin
      j_snoop = snoop(ent_reg.qj_busy, ent_reg.qj, ent_reg.vj,
                      rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
                      rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);
      k_snoop = snoop(ent_reg.qk_busy, ent_reg.qk, ent_reg.vk,
                      rdy_a_cdb_in, rob_id_a_cdb_in, result_a_cdb_in,
                      rdy_l_cdb_in, rob_id_l_cdb_in, result_l_cdb_in);

      ent_next = ent_reg;
      if (clear_in) begin
        ent_next.busy = FALSE;
      end else if (disp_accept && (free_idx == RS_WIDTH'(gi))) begin
        // Dispatch only targets non-busy slots, so it never collides with
        // wakeup or issue of the same slot.
        ent_next = disp_entry;
      end else if (ent_reg.busy) begin
        ent_next.qj_busy = j_snoop.pend;
        ent_next.vj      = j_snoop.val;
        ent_next.qk_busy = k_snoop.pend;
        ent_next.vk      = k_snoop.val;
        if (issue_fire && (ready_idx == RS_WIDTH'(gi))) begin
          ent_next.busy = FALSE;
        end
      end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        ent_reg <= '0;
      end else if (rdy_in) begin
        ent_reg <= ent_next;
      end
    end

    assign busy_vec[gi]  = ent_reg.busy;
    assign ready_vec[gi] = ent_reg.busy && !ent_reg.qj_busy && !ent_reg.qk_busy;
    assign ent_arr[gi]   = ent_reg;
  end

  // -------------------------------------------------------------------------
  // Occupancy count; dispatch and issue on the same edge cancel out.
  // -------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    case ({disp_accept, issue_fire})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_reg      <= '0;
      full_reg       <= FALSE;
      rdy_alu_reg    <= FALSE;
      pc_alu_reg     <= '0;
      opcode_alu_reg <= '0;
      vj_alu_reg     <= '0;
      vk_alu_reg     <= '0;
      imm_alu_reg    <= '0;
      rob_id_alu_reg <= '0;
    end else if (!rdy_in) begin
      // Frozen: only the issue strobe drops so the ALU never sees a repeat.
      rdy_alu_reg <= FALSE;
    end else if (clear_in) begin
      count_reg   <= '0;
      full_reg    <= FALSE;
      rdy_alu_reg <= FALSE;
    end else begin
      count_reg   <= count_next;
      full_reg    <= (count_next == CNT_FULL);
      rdy_alu_reg <= issue_fire;
      if (issue_fire) begin
        pc_alu_reg     <= ent_arr[ready_idx].pc;
        opcode_alu_reg <= ent_arr[ready_idx].opcode;
        vj_alu_reg     <= ent_arr[ready_idx].vj;
        vk_alu_reg     <= ent_arr[ready_idx].vk;
        imm_alu_reg    <= ent_arr[ready_idx].imm;
        rob_id_alu_reg <= ent_arr[ready_idx].rob_id;
      end
    end
  end

  assign full_disp_out  = full_reg;
  assign rdy_alu_out    = rdy_alu_reg;
  assign pc_alu_out     = pc_alu_reg;
  assign opcode_alu_out = opcode_alu_reg;
  assign vj_alu_out     = vj_alu_reg;
  assign vk_alu_out     = vk_alu_reg;
  assign imm_alu_out    = imm_alu_reg;
  assign rob_id_alu_out = rob_id_alu_reg;

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs
// Self-checking bench for alu_rs. Expected issue payloads are queued when the
// stimulus is driven and compared in order as the DUT raises rdy_alu_out.
// ---------------------------------------------------------------------------
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic  clk_in;
  logic  rst_n_in;
  logic  rdy_in;
  logic  clear_in;
  logic  valid_disp_in;
  op_t   opcode_disp_in;
  addr_t pc_disp_in;
  data_t vj_disp_in;
  data_t vk_disp_in;
  rob_t  qj_disp_in;
  rob_t  qk_disp_in;
  logic  qj_busy_disp_in;
  logic  qk_busy_disp_in;
  data_t imm_disp_in;
  rob_t  rob_id_disp_in;
  logic  full_disp_out;
  logic  rdy_a_cdb_in;
  data_t result_a_cdb_in;
  rob_t  rob_id_a_cdb_in;
  logic  rdy_l_cdb_in;
  data_t result_l_cdb_in;
  rob_t  rob_id_l_cdb_in;
  logic  idle_alu_in;
  logic  rdy_alu_out;
  addr_t pc_alu_out;
  op_t   opcode_alu_out;
  data_t vj_alu_out;
  data_t vk_alu_out;
  data_t imm_alu_out;
  rob_t  rob_id_alu_out;

  alu_rs #(.RS_SIZE(16), .RS_WIDTH(4)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .clear_in        (clear_in),
    .valid_disp_in   (valid_disp_in),
    .opcode_disp_in  (opcode_disp_in),
    .pc_disp_in      (pc_disp_in),
    .vj_disp_in      (vj_disp_in),
    .vk_disp_in      (vk_disp_in),
    .qj_disp_in      (qj_disp_in),
    .qk_disp_in      (qk_disp_in),
    .qj_busy_disp_in (qj_busy_disp_in),
    .qk_busy_disp_in (qk_busy_disp_in),
    .imm_disp_in     (imm_disp_in),
    .rob_id_disp_in  (rob_id_disp_in),
    .full_disp_out   (full_disp_out),
    .rdy_a_cdb_in    (rdy_a_cdb_in),
    .result_a_cdb_in (result_a_cdb_in),
    .rob_id_a_cdb_in (rob_id_a_cdb_in),
    .rdy_l_cdb_in    (rdy_l_cdb_in),
    .result_l_cdb_in (result_l_cdb_in),
    .rob_id_l_cdb_in (rob_id_l_cdb_in),
    .idle_alu_in     (idle_alu_in),
    .rdy_alu_out     (rdy_alu_out),
    .pc_alu_out      (pc_alu_out),
    .opcode_alu_out  (opcode_alu_out),
    .vj_alu_out      (vj_alu_out),
    .vk_alu_out      (vk_alu_out),
    .imm_alu_out     (imm_alu_out),
    .rob_id_alu_out  (rob_id_alu_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    rob_t  rob;
    op_t   op;
    addr_t pc;
    data_t vj;
    data_t vk;
    data_t imm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  // Active edge, then settle just past the opposite edge.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  task automatic disp(input op_t op, input addr_t pc, input data_t vj, input data_t vk,
                      input logic qjb, input rob_t qj, input logic qkb, input rob_t qk,
                      input data_t imm, input rob_t rob);
    valid_disp_in   = 1'b1;
    opcode_disp_in  = op;
    pc_disp_in      = pc;
    vj_disp_in      = vj;
    vk_disp_in      = vk;
    qj_busy_disp_in = qjb;
    qj_disp_in      = qj;
    qk_busy_disp_in = qkb;
    qk_disp_in      = qk;
    imm_disp_in     = imm;
    rob_id_disp_in  = rob;
  endtask

  task automatic no_disp();
    valid_disp_in = 1'b0;
  endtask

  task automatic cdb_a(input logic v, input rob_t t, input data_t d);
    rdy_a_cdb_in = v; rob_id_a_cdb_in = t; result_a_cdb_in = d;
  endtask

  task automatic cdb_l(input logic v, input rob_t t, input data_t d);
    rdy_l_cdb_in = v; rob_id_l_cdb_in = t; result_l_cdb_in = d;
  endtask

  task automatic expect_issue(input rob_t rob, input op_t op, input addr_t pc,
                              input data_t vj, input data_t vk, input data_t imm);
    exp_t e;
    e.rob = rob; e.op = op; e.pc = pc; e.vj = vj; e.vk = vk; e.imm = imm;
    exp_q.push_back(e);
  endtask

  // Bounded wait for all queued issues to appear.
  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: compare every issued payload against the next expectation.
  always @(negedge clk_in) begin
    if (rst_n_in && rdy_alu_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", rdy_alu_out, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("issue rob=%0d op=%0d pc=0x%0h vj=0x%0h vk=0x%0h imm=0x%0h",
                 rob_id_alu_out, opcode_alu_out, pc_alu_out, vj_alu_out, vk_alu_out, imm_alu_out);
        check("iss_rob", rob_id_alu_out, mon_e.rob);
        check("iss_op",  opcode_alu_out, mon_e.op);
        check("iss_pc",  pc_alu_out,     mon_e.pc);
        check("iss_vj",  vj_alu_out,     mon_e.vj);
        check("iss_vk",  vk_alu_out,     mon_e.vk);
        check("iss_imm", imm_alu_out,    mon_e.imm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; idle_alu_in = 1'b1;
    valid_disp_in = 1'b0; opcode_disp_in = '0; pc_disp_in = '0; vj_disp_in = '0;
    vk_disp_in = '0; qj_disp_in = '0; qk_disp_in = '0; qj_busy_disp_in = 1'b0;
    qk_busy_disp_in = 1'b0; imm_disp_in = '0; rob_id_disp_in = '0;
    cdb_a(1'b0, '0, '0);
    cdb_l(1'b0, '0, '0);

    // ---- reset state ----
    repeat (2) tick();
    check("rst_rdy",  rdy_alu_out,    1'b0);
    check("rst_full", full_disp_out,  1'b0);
    check("rst_rob",  rob_id_alu_out, 4'd0);
    check("rst_vj",   vj_alu_out,     32'd0);
    rst_n_in = 1'b1;
    tick();

    // ---- asynchronous reset during an issue ----
    disp(OP_ADD, 32'h100, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd9);
    expect_issue(4'd9, OP_ADD, 32'h100, 32'd1, 32'd2, 32'd0);
    tick();
    no_disp();
    tick();
    check("pre_reset_issue", rdy_alu_out, 1'b1);
    #1 rst_n_in = 1'b0;
    #1;
    check("async_rst_rdy",   rdy_alu_out,    1'b0);
    check("async_rst_pc",    pc_alu_out,     32'd0);
    check("async_rst_vj",    vj_alu_out,     32'd0);
    check("async_rst_vk",    vk_alu_out,     32'd0);
    check("async_rst_rob",   rob_id_alu_out, 4'd0);
    check("async_rst_op",    opcode_alu_out, 6'd0);
    check("async_rst_full",  full_disp_out,  1'b0);
    check("async_rst_count", dut.count_reg,  5'd0);
    tick();
    rst_n_in = 1'b1;
    tick();

    // ---- minimum latency after reset ----
    disp(OP_ADDI, 32'h200, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd3, 4'd2);
    expect_issue(4'd2, OP_ADDI, 32'h200, 32'd5, 32'd0, 32'd3);
    tick();
    no_disp();
    check("addi_after_e0", rdy_alu_out, 1'b0);
    tick();
    check("addi_after_e1", rdy_alu_out, 1'b1);
    drain(5);

    // ---- wakeup via LSB bus ----
    disp(OP_ADD, 32'h300, 32'd0, 32'd10, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 4'd4);
    tick();
    no_disp();
    tick();
    tick();
    check("wake_pending", rdy_alu_out, 1'b0);
    cdb_l(1'b1, 4'd7, 32'd32);
    expect_issue(4'd4, OP_ADD, 32'h300, 32'd32, 32'd10, 32'd0);
    tick();
    cdb_l(1'b0, 4'd0, 32'd0);
    check("wake_after_e0", rdy_alu_out, 1'b0);
    tick();
    check("wake_after_e1", rdy_alu_out, 1'b1);
    drain(5);

    // ---- dispatch bypass from A bus ----
    disp(OP_SUB, 32'h400, 32'd6, 32'd0, 1'b0, 4'd0, 1'b1, 4'd3, 32'd0, 4'd5);
    cdb_a(1'b1, 4'd3, 32'hFFFF_FFFF);
    expect_issue(4'd5, OP_SUB, 32'h400, 32'd6, 32'hFFFF_FFFF, 32'd0);
    tick();
    no_disp();
    cdb_a(1'b0, 4'd0, 32'd0);
    tick();
    check("bypass_issue", rdy_alu_out, 1'b1);
    drain(5);

    // ---- fill to full, drop the 17th, then accept it after a free ----
    for (int i = 0; i < 16; i++) begin
      check("fill_not_full", full_disp_out, 1'b0);
      disp(OP_BEQ, 32'h1000 + 32'(4 * i), 32'(i), 32'd0, 1'b1, 4'(i), 1'b0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    check("full_set",   full_disp_out, 1'b1);
    check("full_count", dut.count_reg, 5'd16);
    disp(OP_ADDI, 32'h2000, 32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 4'd15);
    tick();
    check("drop17_full",  full_disp_out, 1'b1);
    check("drop17_count", dut.count_reg, 5'd16);
    check("drop17_noiss", rdy_alu_out,   1'b0);
    cdb_a(1'b1, 4'd5, 32'hABC);
    expect_issue(4'd5, OP_BEQ, 32'h1014, 32'hABC, 32'd0, 32'd0);
    expect_issue(4'd15, OP_ADDI, 32'h2000, 32'h77, 32'd0, 32'd1);
    tick();
    cdb_a(1'b0, 4'd0, 32'd0);
    begin
      logic took;
      took = 1'b0;
      for (int i = 0; i < 10 && !took; i++) begin
        if (!full_disp_out) took = 1'b1;
        tick();
      end
      no_disp();
      check("accept17", took, 1'b1);
    end
    drain(10);
    check("after17_count", dut.count_reg, 5'd15);
    check("after17_full",  full_disp_out, 1'b0);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("clear_count", dut.count_reg, 5'd0);

    // ---- ordering: entries 2 and 5 ready together, ALU busy for 2 cycles ----
    for (int i = 0; i < 6; i++) begin
      disp(OP_ADD, 32'h3000 + 32'(4 * i), 32'd0, 32'(100 + i), 1'b1, 4'(8 + i),
           1'b0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    no_disp();
    idle_alu_in = 1'b0;
    cdb_a(1'b1, 4'd10, 32'h222);
    cdb_l(1'b1, 4'd13, 32'h555);
    tick();
    cdb_a(1'b0, 4'd0, 32'd0);
    cdb_l(1'b0, 4'd0, 32'd0);
    check("idle_low_0", rdy_alu_out, 1'b0);
    tick();
    check("idle_low_1", rdy_alu_out, 1'b0);
    tick();
    check("idle_low_2", rdy_alu_out, 1'b0);
    expect_issue(4'd2, OP_ADD, 32'h3008, 32'h222, 32'd102, 32'd0);
    expect_issue(4'd5, OP_ADD, 32'h3014, 32'h555, 32'd105, 32'd0);
    idle_alu_in = 1'b1;
    tick();
    check("order_first",  rob_id_alu_out, 4'd2);
    tick();
    check("order_second", rob_id_alu_out, 4'd5);
    check("order_rdy",    rdy_alu_out,    1'b1);
    tick();
    check("order_count",  dut.count_reg,  5'd4);

    // ---- flush with 4 entries busy ----
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("flush_count", dut.count_reg, 5'd0);
    check("flush_full",  full_disp_out, 1'b0);
    check("flush_rdy",   rdy_alu_out,   1'b0);
    cdb_a(1'b1, 4'd8, 32'h1);
    cdb_l(1'b1, 4'd9, 32'h2);
    tick();
    cdb_a(1'b1, 4'd11, 32'h3);
    cdb_l(1'b1, 4'd12, 32'h4);
    tick();
    cdb_a(1'b0, 4'd0, 32'd0);
    cdb_l(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_issue", rdy_alu_out, 1'b0);
      tick();
    end

    // ---- freeze: broadcast and dispatch ignored while rdy_in low ----
    disp(OP_ADD, 32'h500, 32'd0, 32'd20, 1'b1, 4'd6, 1'b0, 4'd0, 32'd0, 4'd7);
    tick();
    disp(OP_ADD, 32'h504, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd8);
    rdy_in = 1'b0;
    cdb_a(1'b1, 4'd6, 32'h99);
    tick();
    no_disp();
    cdb_a(1'b0, 4'd0, 32'd0);
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("freeze_pending", rdy_alu_out, 1'b0);
      tick();
    end
    check("freeze_count", dut.count_reg, 5'd1);
    cdb_a(1'b1, 4'd6, 32'h99);
    expect_issue(4'd7, OP_ADD, 32'h500, 32'h99, 32'd20, 32'd0);
    tick();
    cdb_a(1'b0, 4'd0, 32'd0);
    drain(5);
    check("final_count", dut.count_reg, 5'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
